scoreboard_hazard_unit: RTL and testbench

- Parametrised, stateful successor to the ID-stage hazard detector.
- Keeps a per-register pending-latency scoreboard, so producers may have any result latency from 1 to MAX_LAT (ALU, load, multiply, divide).
- Raises a stall to the ID stage for RAW hazards, WAW ordering violations, and structural occupancy of the unpipelined divider.
- Sits between ID and the pipeline control that freezes PC/IF-ID and injects EXE bubbles.

---
 rtl/hazard_pkg.sv | 45 ++++
 rtl/pending_counter.sv | 49 ++++
 rtl/scoreboard_hazard_unit.sv | 133 +++++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the scoreboard hazard unit and the ID-stage decoder
// that drives it:
//   - stall_reason_e : one-hot stall cause reported to pipeline control
//   - LAT_*          : producer result latencies used by the decoder
//   - OP_* / FN_*    : opcode / funct values the decoder keys on
//   - clamp_lat      : limits a requested latency to the range [1, max_lat]
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [2:0] {
        RSN_NONE   = 3'b000,
        RSN_RAW    = 3'b001,
        RSN_WAW    = 3'b010,
        RSN_STRUCT = 3'b100
    } stall_reason_e;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_MUL  = 4;

    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;

    // A latency of 0 makes no sense for a producer, so it is treated as 1;
    // anything beyond the tracked range saturates.
    function automatic int clamp_lat(input int lat, input int max_lat);
        if (lat < 1) begin
            return 1;
        end
        if (lat > max_lat) begin
            return max_lat;
        end
        return lat;
    endfunction

endpackage

// File: rtl/pending_counter.sv
// -----------------------------------------------------------------------------
// pending_counter
// One scoreboard entry: cycles remaining until the register's in-flight
// result reaches the forwarding network.
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   load_i in   a new producer of this register issues this cycle
//   lat_i  in   requested latency (clamped to [1, MAX_LAT] on load)
//   cnt_o  out  remaining latency, 0 when nothing is pending
// -----------------------------------------------------------------------------
module pending_counter
    import hazard_pkg::*;
#(
    parameter int MAX_LAT = 8,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;
    logic [LAT_W-1:0] lat_sat;

    // A load wins over the decrement of the previous producer's count.
    always_comb begin
        lat_sat = LAT_W'(clamp_lat(32'(lat_i), MAX_LAT));
        cnt_d   = cnt_q;
        if (load_i) begin
            cnt_d = lat_sat;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_unit
// ID-stage hazard detector with a per-register pending-latency scoreboard.
// Stalls ID (and bubbles EXE) on RAW hazards, WAW ordering violations and
// occupancy of the unpipelined divider.
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid, id_flush          ID holds a real / squashed instruction
//   id_src1, id_src2            source register indices
//   id_src1_used, id_src2_used  source actually read
//   id_is_branch                operands consumed in ID (no EXE forwarding)
//   id_dst, id_dst_we           destination index and write enable
//   id_latency                  issue-to-forwarding latency of the result
//   id_uses_div                 instruction occupies the divider
//   stall                       hold ID, bubble EXE (combinational)
//   stall_reason                one-hot {STRUCT, WAW, RAW}, 0 when not stalled
//   stall_count                 saturating count of stalled cycles
// -----------------------------------------------------------------------------
module scoreboard_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_COUNT  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_LAT    = 8,
    parameter int LAT_W      = $clog2(MAX_LAT + 1),
    parameter int DIV_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_flush,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_used,
    input  logic                  id_src2_used,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_dst_we,
    input  logic [LAT_W-1:0]      id_latency,
    input  logic                  id_uses_div,
    output logic                  stall,
    output logic [2:0]            stall_reason,
    output logic [31:0]           stall_count
);

    localparam int DIV_W = $clog2(DIV_CYCLES + 1);

    logic [LAT_W-1:0] pending [REG_COUNT];
    logic             issue;
    logic             dst_wr;
    logic [LAT_W-1:0] lat_sat;
    logic [LAT_W-1:0] allow;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             structural;
    stall_reason_e    reason;
    logic [DIV_W-1:0] div_busy_q;
    logic [DIV_W-1:0] div_busy_d;
    logic [31:0]      stall_count_q;
    logic [31:0]      stall_count_d;

    assign issue  = id_valid && !id_flush && !stall;
    assign dst_wr = id_dst_we && (id_dst != '0);

    // r0 is hardwired zero, so it never has a pending producer.
    assign pending[0] = '0;

    for (genvar r = 1; r < REG_COUNT; r++) begin : g_entry
        pending_counter #(
            .MAX_LAT (MAX_LAT),
            .LAT_W   (LAT_W)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (issue && dst_wr && (id_dst == REG_ADDR_W'(r))),
            .lat_i  (id_latency),
            .cnt_o  (pending[r])
        );
    end

    always_comb begin
        lat_sat = LAT_W'(clamp_lat(32'(id_latency), MAX_LAT));
        // A count of 1 means the producer forwards next cycle into EXE, which
        // a normal consumer can take; a branch reads in ID and must wait it out.
        allow   = id_is_branch ? '0 : LAT_W'(1);
        raw1    = id_src1_used && (id_src1 != '0) && (pending[id_src1] > allow);
        raw2    = id_src2_used && (id_src2 != '0) && (pending[id_src2] > allow);
        // Younger write may not land before an older one to the same register.
        waw     = dst_wr && (pending[id_dst] > lat_sat);
        structural = id_uses_div && (div_busy_q != '0);
        stall   = id_valid && !id_flush && (raw1 || raw2 || waw || structural);

        reason = RSN_NONE;
        if (stall) begin
            if (structural) begin
                reason = RSN_STRUCT;
            end else if (waw) begin
                reason = RSN_WAW;
            end else begin
                reason = RSN_RAW;
            end
        end
    end

    assign stall_reason = reason;

    always_comb begin
        div_busy_d = div_busy_q;
        if (issue && id_uses_div) begin
            div_busy_d = DIV_W'(DIV_CYCLES - 1);
        end else if (div_busy_q != '0) begin
            div_busy_d = div_busy_q - DIV_W'(1);
        end

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy_q    <= '0;
            stall_count_q <= '0;
        end else begin
            div_busy_q    <= div_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
// Directed bench for scoreboard_hazard_unit with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// mid-cycle, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_flush;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_src1_used;
    logic        id_src2_used;
    logic        id_is_branch;
    logic [4:0]  id_dst;
    logic        id_dst_we;
    logic [3:0]  id_latency;
    logic        id_uses_div;
    logic        stall;
    logic [2:0]  stall_reason;
    logic [31:0] stall_count;

    int checks;
    int errors;
    int n;

    scoreboard_hazard_unit #(
        .REG_COUNT  (32),
        .REG_ADDR_W (5),
        .MAX_LAT    (8),
        .DIV_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_flush     (id_flush),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_src1_used (id_src1_used),
        .id_src2_used (id_src2_used),
        .id_is_branch (id_is_branch),
        .id_dst       (id_dst),
        .id_dst_we    (id_dst_we),
        .id_latency   (id_latency),
        .id_uses_div  (id_uses_div),
        .stall        (stall),
        .stall_reason (stall_reason),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_flush     = 1'b0;
        id_src1      = '0;
        id_src2      = '0;
        id_src1_used = 1'b0;
        id_src2_used = 1'b0;
        id_is_branch = 1'b0;
        id_dst       = '0;
        id_dst_we    = 1'b0;
        id_latency   = '0;
        id_uses_div  = 1'b0;
        #1;
    endtask

    task automatic instr(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                         input logic u2, input logic br, input logic [4:0] dst,
                         input logic we, input logic [3:0] lat, input logic dv,
                         input logic fl);
        id_valid     = 1'b1;
        id_flush     = fl;
        id_src1      = s1;
        id_src1_used = u1;
        id_src2      = s2;
        id_src2_used = u2;
        id_is_branch = br;
        id_dst       = dst;
        id_dst_we    = we;
        id_latency   = lat;
        id_uses_div  = dv;
        #1;
    endtask

    // Counts consecutive stalled cycles of the instruction held in ID.
    task automatic count_stalls(output int cnt);
        cnt = 0;
        while (stall && cnt < 64) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        tick();
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_reason", 32'(stall_reason), 32'd0);
        chk("reset_count", 32'(stall_count), 32'd0);
        chk("reset_pend3", 32'(dut.pending[3]), 32'd0);
        rst_n = 1'b1;
        instr(5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("post_reset_stall", 32'(stall), 32'd0);

        // ALU r3 then back-to-back consumer
        instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("alu_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_pend3_a", 32'(dut.pending[3]), 32'd1);
        instr(5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("alu_fwd_stall", 32'(stall), 32'd0);
        tick();
        chk("alu_pend3_b", 32'(dut.pending[3]), 32'd0);
        idle();

        // Load-use: one RAW stall
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        instr(5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 5'd11, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_reason", 32'(stall_reason), 32'd1);
        tick();
        chk("lu_release", 32'(stall), 32'd0);
        tick();
        chk("lu_count", stall_count, 32'd1);
        idle();
        tick();

        // Branch consumers
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        instr(5'd6, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("br_alu_reason", 32'(stall_reason), 32'd1);
        count_stalls(n);
        chk("br_alu_cycles", 32'(n), 32'd1);
        tick();
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 4'd2, 1'b0, 1'b0);
        tick();
        instr(5'd6, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0);
        count_stalls(n);
        chk("br_load_cycles", 32'(n), 32'd2);
        tick();
        chk("br_count", stall_count, 32'd4);
        idle();
        tick();

        // Divider occupancy
        instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd12, 1'b1, 4'd8, 1'b1, 1'b0);
        chk("div1_stall", 32'(stall), 32'd0);
        tick();
        idle();
        tick();
        tick();
        tick();
        instr(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 4'd8, 1'b1, 1'b0);
        chk("div2_reason", 32'(stall_reason), 32'd4);
        count_stalls(n);
        chk("div2_cycles", 32'(n), 32'd12);
        tick();
        chk("div_count", stall_count, 32'd16);

        // STRUCT outranks WAW
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 4'd4, 1'b0, 1'b0);
        chk("mul_issue_stall", 32'(stall), 32'd0);
        tick();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 4'd1, 1'b1, 1'b0);
        chk("prio_stall", 32'(stall), 32'd1);
        chk("prio_reason", 32'(stall_reason), 32'd4);
        idle();
        repeat (20) tick();

        // WAW: MUL r7 (lat 4), bubble, ADD r7 (lat 1)
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 4'd4, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("waw_reason", 32'(stall_reason), 32'd2);
        count_stalls(n);
        chk("waw_cycles", 32'(n), 32'd2);
        tick();
        chk("waw_count", stall_count, 32'd18);
        idle();
        tick();

        // Flushed load leaves no trace
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 4'd2, 1'b0, 1'b1);
        chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_pend8", 32'(dut.pending[8]), 32'd0);
        instr(5'd8, 1'b1, 5'd1, 1'b1, 1'b0, 5'd15, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("flush_use_stall", 32'(stall), 32'd0);
        tick();
        idle();

        // r0 writes and latency saturation
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 4'd8, 1'b0, 1'b0);
        tick();
        chk("r0_pend", 32'(dut.pending[0]), 32'd0);
        instr(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 4'd1, 1'b0, 1'b0);
        chk("r0_use_stall", 32'(stall), 32'd0);
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 4'd15, 1'b0, 1'b0);
        tick();
        chk("sat_pend10", 32'(dut.pending[10]), 32'd8);
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        chk("lat0_pend14", 32'(dut.pending[14]), 32'd1);
        chk("sat_count", stall_count, 32'd18);
        idle();

        // Asynchronous reset mid-operation
        instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 4'd3, 1'b0, 1'b0);
        tick();
        chk("rst_pend9_pre", 32'(dut.pending[9]), 32'd3);
        instr(5'd9, 1'b1, 5'd1, 1'b1, 1'b0, 5'd16, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("rst_pre_stall", 32'(stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_pend9", 32'(dut.pending[9]), 32'd0);
        chk("rst_pend10", 32'(dut.pending[10]), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_reason", 32'(stall_reason), 32'd0);
        chk("rst_count", stall_count, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_stall", 32'(stall), 32'd0);
        chk("rel_reason", 32'(stall_reason), 32'd0);
        tick();
        chk("rel_pend16", 32'(dut.pending[16]), 32'd1);
        chk("rel_count", stall_count, 32'd0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
